// File: rtl/nrzi_unstuff_rx.sv
// Purpose : NRZI line decoder with bit-unstuffing and per-packet bit counting.
// Latency : every output is registered; responses appear 1 cycle after the causing input.
// Backpr. : none; the block accepts one bit per bstr_in_ready cycle and never stalls.
//
// Ports
//   clk            sole clock, rising edge
//   rst_b          synchronous active-low reset
//   bstr_in        NRZI line level, valid when bstr_in_ready=1
//   bstr_in_ready  a bit is present on bstr_in this cycle
//   in_done        one-cycle end-of-packet pulse
//   bstr_out       decoded, unstuffed data bit (holds when not valid)
//   bstr_out_ready bstr_out carries a delivered bit this cycle
//   out_done       one-cycle end-of-packet pulse
//   stuff_err      one-cycle pulse on a stuffing violation
//   bit_count      bits delivered in the current packet, saturating
module nrzi_unstuff_rx #(
    parameter int   STUFF_LEN   = 6,
    parameter logic IDLE_LEVEL  = 1'b1,
    parameter int   CHECK_STUFF = 1,
    parameter int   CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bstr_in,
    input  logic             bstr_in_ready,
    input  logic             in_done,
    output logic             bstr_out,
    output logic             bstr_out_ready,
    output logic             out_done,
    output logic             stuff_err,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [3:0]       STUFF_LIM = 4'(STUFF_LEN);
    localparam logic             CHECK_EN  = (CHECK_STUFF != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       ONES_MAX  = 4'hF;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             last_nxt;
    logic [3:0]       ones_cnt;
    logic [3:0]       ones_nxt;
    logic             bstr_out_nxt;
    logic             ready_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_base;

    logic proc;       // a bit is accepted for decoding this cycle
    logic d;          // decoded data bit
    logic stuff_pos;  // the current bit sits in a stuff slot
    logic drop;       // valid stuff bit: discarded silently
    logic flag;       // a 1 where a stuff 0 was required
    logic deliver;    // bit goes out on bstr_out

    // Decode and classify the incoming bit. In ERR the line is ignored
    // entirely until the packet is closed by in_done.
    always_comb begin : decode
        proc      = bstr_in_ready && (state != ERR);
        d         = (bstr_in == last);
        stuff_pos = CHECK_EN && (ones_cnt == STUFF_LIM);
        drop      = proc && stuff_pos && !d;
        flag      = proc && stuff_pos && d;
        deliver   = proc && !stuff_pos;
    end

    // State register.
    always_ff @(posedge clk) begin : state_reg
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. in_done always closes the packet; a bit arriving
    // in the same cycle has already been accounted for by the datapath.
    always_comb begin : next_state
        state_nxt = state;
        if (in_done) begin
            state_nxt = IDLE;
        end else if (flag) begin
            state_nxt = ERR;
        end else if (proc) begin
            state_nxt = RUN;
        end
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin : outputs
        last_nxt     = last;
        ones_nxt     = ones_cnt;
        bstr_out_nxt = bstr_out;
        ready_nxt    = 1'b0;
        done_nxt     = in_done;
        err_nxt      = flag;

        // Any bit seen in IDLE opens a new packet, so the count restarts
        // from zero; in_done alone in IDLE closes an empty packet.
        if ((state == IDLE) && (bstr_in_ready || in_done)) begin
            count_base = '0;
        end else begin
            count_base = bit_count;
        end
        count_nxt = count_base;

        if (proc) begin
            last_nxt = bstr_in;
            if (drop || flag) begin
                ones_nxt = '0;
            end else if (d) begin
                // Only reachable above STUFF_LEN when checking is disabled.
                ones_nxt = (ones_cnt == ONES_MAX) ? ONES_MAX : ones_cnt + 4'd1;
            end else begin
                ones_nxt = '0;
            end
        end

        if (deliver) begin
            bstr_out_nxt = d;
            ready_nxt    = 1'b1;
            count_nxt    = (count_base == CNT_MAX) ? CNT_MAX : count_base + 1'b1;
        end

        // Packet end overrides the line history so the next packet starts
        // decoding against the idle level.
        if (in_done) begin
            last_nxt = IDLE_LEVEL;
            ones_nxt = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin : data_reg
        if (!rst_b) begin
            last           <= IDLE_LEVEL;
            ones_cnt       <= '0;
            bit_count      <= '0;
            bstr_out       <= 1'b0;
            bstr_out_ready <= 1'b0;
            out_done       <= 1'b0;
            stuff_err      <= 1'b0;
        end else begin
            last           <= last_nxt;
            ones_cnt       <= ones_nxt;
            bit_count      <= count_nxt;
            bstr_out       <= bstr_out_nxt;
            bstr_out_ready <= ready_nxt;
            out_done       <= done_nxt;
            stuff_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Purpose : directed bench for nrzi_unstuff_rx, default and CHECK_STUFF=0 instances.
// Latency : expectations are queued when a step is driven and compared one edge later.
// Backpr. : none; inputs are driven every cycle.
module tb_nrzi_unstuff_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        bstr_in;
    logic        bstr_in_ready;
    logic        in_done;

    logic        out1, rdy1, done1, err1;
    logic [10:0] cnt1;
    logic        out2, rdy2, done2, err2;
    logic [10:0] cnt2;

    nrzi_unstuff_rx dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .bstr_in       (bstr_in),
        .bstr_in_ready (bstr_in_ready),
        .in_done       (in_done),
        .bstr_out      (out1),
        .bstr_out_ready(rdy1),
        .out_done      (done1),
        .stuff_err     (err1),
        .bit_count     (cnt1)
    );

    nrzi_unstuff_rx #(.CHECK_STUFF(0)) dut_nochk (
        .clk           (clk),
        .rst_b         (rst_b),
        .bstr_in       (bstr_in),
        .bstr_in_ready (bstr_in_ready),
        .in_done       (in_done),
        .bstr_out      (out2),
        .bstr_out_ready(rdy2),
        .out_done      (done2),
        .stuff_err     (err2),
        .bit_count     (cnt2)
    );

    typedef struct {
        logic rdy, out, done, err;
        int   cnt;
        logic rdy2, out2, err2;
        int   cnt2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of input, queue its expected response, compare after the edge.
    task automatic step(input string tag, input logic lvl, input logic rdy, input logic dn,
                        input logic er, input logic eo, input logic ed, input logic ee,
                        input int ec, input logic er2, input logic eo2, input logic ee2,
                        input int ec2);
        exp_t e;
        bstr_in       = lvl;
        bstr_in_ready = rdy;
        in_done       = dn;
        e = '{rdy: er, out: eo, done: ed, err: ee, cnt: ec,
              rdy2: er2, out2: eo2, err2: ee2, cnt2: ec2};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rdy"},   32'(rdy1),  32'(e.rdy));
            chk({tag, ".out"},   32'(out1),  32'(e.out));
            chk({tag, ".done"},  32'(done1), 32'(e.done));
            chk({tag, ".err"},   32'(err1),  32'(e.err));
            chk({tag, ".cnt"},   32'(cnt1),  32'(e.cnt));
            chk({tag, ".rdy2"},  32'(rdy2),  32'(e.rdy2));
            chk({tag, ".out2"},  32'(out2),  32'(e.out2));
            chk({tag, ".done2"}, 32'(done2), 32'(e.done));
            chk({tag, ".err2"},  32'(err2),  32'(e.err2));
            chk({tag, ".cnt2"},  32'(cnt2),  32'(e.cnt2));
        end
    endtask

    initial begin
        rst_b         = 1'b0;
        bstr_in       = 1'b0;
        bstr_in_ready = 1'b0;
        in_done       = 1'b0;

        // Reset holds everything at zero even with live inputs.
        step("rst0", 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        step("rst1", 1, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        rst_b = 1'b1;

        // Levels 1,0,0,1 decode to 1,0,1,0.
        step("t1b0", 1, 1, 0,  1, 1, 0, 0, 1,  1, 1, 0, 1);
        step("t1b1", 0, 1, 0,  1, 0, 0, 0, 2,  1, 0, 0, 2);
        step("t1b2", 0, 1, 0,  1, 1, 0, 0, 3,  1, 1, 0, 3);
        step("t1b3", 1, 1, 0,  1, 0, 0, 0, 4,  1, 0, 0, 4);
        step("t1done", 0, 0, 1,  0, 0, 1, 0, 4,  0, 0, 0, 4);
        step("t1idle", 0, 0, 0,  0, 0, 0, 0, 4,  0, 0, 0, 4);

        // Six ones then a stuff zero: dropped here, delivered without checking.
        for (int i = 0; i < 6; i++)
            step("t2one", 1, 1, 0,  1, 1, 0, 0, i + 1,  1, 1, 0, i + 1);
        step("t2stuff", 0, 1, 0,  0, 1, 0, 0, 6,  1, 0, 0, 7);
        step("t2after", 0, 1, 0,  1, 1, 0, 0, 7,  1, 1, 0, 8);
        step("t2done", 0, 0, 1,  0, 1, 1, 0, 7,  0, 1, 0, 8);

        // Seven ones: violation, then the line is ignored until in_done.
        for (int i = 0; i < 6; i++)
            step("t3one", 1, 1, 0,  1, 1, 0, 0, i + 1,  1, 1, 0, i + 1);
        step("t3viol", 1, 1, 0,  0, 1, 0, 1, 6,  1, 1, 0, 7);
        step("t3ign0", 0, 1, 0,  0, 1, 0, 0, 6,  1, 0, 0, 8);
        step("t3ign1", 1, 1, 0,  0, 1, 0, 0, 6,  1, 0, 0, 9);
        step("t3done", 0, 0, 1,  0, 1, 1, 0, 6,  0, 0, 0, 9);

        // Gaps (with the line wiggling) do not disturb decoding; last bit meets in_done.
        step("t4b0",   0, 1, 0,  1, 0, 0, 0, 1,  1, 0, 0, 1);
        step("t4gap0", 1, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 1);
        step("t4gap1", 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 1);
        step("t4b1",   0, 1, 0,  1, 1, 0, 0, 2,  1, 1, 0, 2);
        step("t4gap2", 1, 0, 0,  0, 1, 0, 0, 2,  0, 1, 0, 2);
        step("t4last", 1, 1, 1,  1, 0, 1, 0, 3,  1, 0, 0, 3);
        step("t4idle", 0, 0, 0,  0, 0, 0, 0, 3,  0, 0, 0, 3);

        // Stuff bit coincident with in_done is still dropped before closing.
        for (int i = 0; i < 6; i++)
            step("t5one", 1, 1, 0,  1, 1, 0, 0, i + 1,  1, 1, 0, i + 1);
        step("t5stuffdone", 0, 1, 1,  0, 1, 1, 0, 6,  1, 0, 0, 7);
        step("t5idle", 0, 0, 0,  0, 1, 0, 0, 6,  0, 0, 0, 7);

        // Empty packet: in_done alone in IDLE clears the count.
        step("t6done", 0, 0, 1,  0, 1, 1, 0, 0,  0, 0, 0, 0);

        // Reset mid-packet aborts silently; next bit decodes against the idle level.
        step("t7b0", 1, 1, 0,  1, 1, 0, 0, 1,  1, 1, 0, 1);
        step("t7b1", 0, 1, 0,  1, 0, 0, 0, 2,  1, 0, 0, 2);
        rst_b = 1'b0;
        step("t7rst", 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        rst_b = 1'b1;
        step("t7after", 1, 1, 0,  1, 1, 0, 0, 1,  1, 1, 0, 1);
        step("t7done", 0, 0, 1,  0, 1, 1, 0, 1,  0, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
